// File: rtl/accel_dispatcher.sv
// accel_dispatcher: host-side initiator for the series-evaluation accelerator.
// Takes one operand from an upstream valid/ready stream and drives a held
// start pulse. It then follows the accelerator's ready flag as it falls and
// rises again, captures the result and offers it downstream on valid/ack.
//
// Optional build macro: TIMEOUT_EN adds a watchdog over the wait states.
// When it trips, the job is abandoned and a sticky err flag is raised.
//
// Ports:
//   clk, rst              rising-edge clock, async active-high reset
//   in_valid/in_ready/in_x   upstream operand stream
//   acc_start/acc_x       start strobe and operand to the accelerator
//   acc_ready/acc_r       accelerator idle/done flag and result
//   out_valid/out_r/out_ack  downstream result handshake
//   busy                  job in flight
//   err                   sticky watchdog timeout (0 without TIMEOUT_EN)
//   job_cnt               completed jobs, wraps at 256
module accel_dispatcher #(
  parameter int unsigned XW         = 16,
  parameter int unsigned RW         = 16,
  parameter int unsigned START_HOLD = 2,
  parameter int unsigned TO_CYC     = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [XW-1:0] in_x,
  output logic          acc_start,
  output logic [XW-1:0] acc_x,
  input  logic          acc_ready,
  input  logic [RW-1:0] acc_r,
  output logic          out_valid,
  output logic [RW-1:0] out_r,
  input  logic          out_ack,
  output logic          busy,
  output logic          err,
  output logic [7:0]    job_cnt
);

  localparam int unsigned HW = 4;
  localparam logic [HW-1:0] HOLD_LAST = HW'(START_HOLD - 1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    ISSUE       = 3'd1,
    ACCEPT_WAIT = 3'd2,
    RUN_WAIT    = 3'd3,
    DONE        = 3'd4
  } state_t;

  state_t        state, state_nx;
  logic          rdy_en;
  logic          seen_low;
  logic [HW-1:0] hold_cnt;
  logic          accept;
  logic          issue_end;
  logic          timeout_c;

  // Ready depends only on registered state, never on in_valid.
  assign in_ready  = (state == IDLE) & rdy_en & acc_ready;
  assign accept    = in_ready & in_valid;
  assign issue_end = (state == ISSUE) && (hold_cnt == HOLD_LAST);

`ifdef TIMEOUT_EN
  localparam int unsigned WDW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TO_CYC - 1);

  logic [WDW-1:0] wd_cnt;

  // A completion seen in RUN_WAIT wins over a coincident watchdog expiry.
  assign timeout_c = (wd_cnt == WD_LAST) &&
                     ((state == ACCEPT_WAIT) || ((state == RUN_WAIT) && !acc_ready));

  // Watchdog counter and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if (accept)         err <= 1'b0;
      else if (timeout_c) err <= 1'b1;
      if (issue_end)
        wd_cnt <= '0;
      else if ((state == ACCEPT_WAIT) || (state == RUN_WAIT))
        wd_cnt <= wd_cnt + WDW'(1);
    end
  end
`else
  // Watchdog limit only matters when TIMEOUT_EN is defined.
  logic unused_to_cyc;
  assign unused_to_cyc = |32'(TO_CYC);
  assign timeout_c     = 1'b0;
  assign err           = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:        if (accept) state_nx = ISSUE;
      ISSUE:       if (issue_end) state_nx = ACCEPT_WAIT;
      ACCEPT_WAIT: begin
        if (timeout_c)     state_nx = IDLE;
        else if (seen_low) state_nx = RUN_WAIT;
      end
      RUN_WAIT: begin
        if (acc_ready)      state_nx = DONE;
        else if (timeout_c) state_nx = IDLE;
      end
      DONE:        if (out_ack) state_nx = IDLE;
      default:     state_nx = IDLE;
    endcase
  end

  // Registered outputs and job bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_en    <= 1'b0;
      seen_low  <= 1'b0;
      hold_cnt  <= '0;
      acc_start <= 1'b0;
      acc_x     <= '0;
      out_valid <= 1'b0;
      out_r     <= '0;
      busy      <= 1'b0;
      job_cnt   <= '0;
    end else begin
      rdy_en <= 1'b1;
      busy   <= (state_nx != IDLE);
      case (state)
        IDLE: begin
          if (accept) begin
            acc_x     <= in_x;
            seen_low  <= 1'b0;
            hold_cnt  <= '0;
            acc_start <= 1'b1;
          end
        end
        ISSUE: begin
          // A ready drop while start is still held already counts as accepted.
          if (!acc_ready) seen_low <= 1'b1;
          if (issue_end) acc_start <= 1'b0;
          else           hold_cnt  <= hold_cnt + HW'(1);
        end
        ACCEPT_WAIT: begin
          if (!acc_ready) seen_low <= 1'b1;
        end
        RUN_WAIT: begin
          if (acc_ready) begin
            out_r     <= acc_r;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ack) begin
            out_valid <= 1'b0;
            job_cnt   <= job_cnt + 8'd1;
          end
        end
        default: begin
          acc_start <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accel_dispatcher.sv
// Randomized self-checking bench for accel_dispatcher.
// An accelerator model drives acc_ready/acc_r per job. Expected outputs are
// derived per cycle from the job-level timing rules.
module tb_accel_dispatcher;

  localparam int XW = 16;
  localparam int RW = 16;
  localparam int SH = 2;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [XW-1:0] in_x;
  logic          acc_start;
  logic [XW-1:0] acc_x;
  logic          acc_ready;
  logic [RW-1:0] acc_r;
  logic          out_valid;
  logic [RW-1:0] out_r;
  logic          out_ack;
  logic          busy;
  logic          err;
  logic [7:0]    job_cnt;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_cnt = 8'd0;

  accel_dispatcher #(.XW(XW), .RW(RW), .START_HOLD(SH), .TO_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .acc_start(acc_start), .acc_x(acc_x),
    .acc_ready(acc_ready), .acc_r(acc_r),
    .out_valid(out_valid), .out_r(out_r), .out_ack(out_ack),
    .busy(busy), .err(err), .job_cnt(job_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  task automatic check_reset_vals();
    check("rst_in_ready", in_ready, 0);
    check("rst_acc_start", acc_start, 0);
    check("rst_acc_x", acc_x, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_r", out_r, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_job_cnt", job_cnt, 0);
  endtask

  // Reset release: in_ready stays low until the first clock afterwards.
  task automatic release_reset();
    acc_ready = 1'b1; in_valid = 1'b0; out_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1 check("in_ready_pre_clk", in_ready, 0);
    @(negedge clk);
    check("in_ready_post_clk", in_ready, 1);
  endtask

  // One job. Edge N is the accept edge; edge N+k is "k". The model samples
  // acc_ready low at edges l..h-1 and high again from h, with acc_r=r from h.
  // Start is held for edges 1..SH. The low ready is registered, so the wait
  // for it ends no earlier than l+1. Capture needs ready high in the run
  // wait that follows, hence the max.
  task automatic job(input logic [XW-1:0] x, input int l, input int h,
                     input logic [RW-1:0] r, input int ack_wait, input int abort_k);
    int c, d;
    bit got;
    c = max3(h, l + 2, SH + 2);
    d = c + ack_wait + 1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (in_ready) got = 1'b1;
      else @(negedge clk);
    end
    check("in_ready_wait", got, 1);
    if (!got) return;
    in_valid = 1'b1; in_x = x; acc_ready = 1'b1; acc_r = RW'($urandom);
    @(negedge clk);
    for (int k = 0; k < d; k++) begin
      if (abort_k != 0 && k == abort_k) begin
        rst = 1'b1;
        #1 check_reset_vals();
        exp_cnt = 8'd0;
        release_reset();
        return;
      end
      check("acc_x", acc_x, x);
      check("acc_start", acc_start, (k < SH) ? 1 : 0);
      check("out_valid", out_valid, (k >= c) ? 1 : 0);
      if (k >= c) check("out_r", out_r, r);
      check("busy", busy, 1);
      check("in_ready_busy", in_ready, 0);
      check("err", err, 0);
      check("job_cnt", job_cnt, exp_cnt);
      // Upstream keeps presenting junk operands; they must be ignored.
      in_valid  = 1'b1;
      in_x      = XW'($urandom);
      acc_ready = !((k + 1) >= l && (k + 1) < h);
      acc_r     = ((k + 1) >= h) ? r : RW'($urandom);
      out_ack   = ((k + 1) <= c) ? 1'($urandom_range(0, 1)) : ((k + 1) == d);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ack = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
    check("drain_out_valid", out_valid, 0);
    check("drain_busy", busy, 0);
    check("drain_job_cnt", job_cnt, exp_cnt);
    check("drain_in_ready", in_ready, 1);
    check("drain_acc_x", acc_x, x);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_x = '0; acc_ready = 1'b1; acc_r = '0; out_ack = 1'b0;
    @(negedge clk);
    #1 check_reset_vals();
    release_reset();

`ifdef TIMEOUT_EN
    // Ready falls and never returns: watchdog trips 16 cycles after the
    // wait begins at edge SH.
    in_valid = 1'b1; in_x = 16'h00AA;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < SH + TO + 3; k++) begin
      check("to_err", err, (k >= SH + TO) ? 1 : 0);
      check("to_busy", busy, (k < SH + TO) ? 1 : 0);
      check("to_out_valid", out_valid, 0);
      check("to_job_cnt", job_cnt, exp_cnt);
      acc_ready = 1'b0;
      @(negedge clk);
    end
    check("to_in_ready_low", in_ready, 0);
    acc_ready = 1'b1;
    @(negedge clk);
    check("to_in_ready", in_ready, 1);
    check("to_err_held", err, 1);
    job(16'h0005, 2, 8, 16'h5A5A, 1, 0);
`else
    // Single job with the documented timing.
    job(16'h0003, 2, 21, 16'h1234, 0, 0);
    // Ready drops only three cycles after start is released.
    job(16'hBEEF, SH + 3, SH + 13, 16'h0F0F, 2, 0);
    // Long back-pressure on the result.
    job(16'h1111, 1, 7, 16'hCAFE, 50, 0);
    // Reset in the middle of a run, then a clean job.
    job(16'h2222, 2, 60, 16'hDEAD, 0, 10);
    job(16'h0007, 2, 9, 16'h7777, 1, 0);
    // Back-to-back random jobs; the count wraps past 255.
    for (int j = 0; j < 256; j++) begin
      int l;
      l = $urandom_range(1, 6);
      job(XW'($urandom), l, l + $urandom_range(1, 12), RW'($urandom),
          $urandom_range(0, 4), 0);
    end
    check("wrap_job_cnt", job_cnt, 8'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
